// File: rtl/vga_game_pkg.sv
// Shared VGA 640x480@60 timing constants, colours and ball direction type.
package vga_game_pkg;

  localparam logic [9:0] H_VISIBLE = 10'd640;
  localparam logic [9:0] H_FP      = 10'd16;
  localparam logic [9:0] H_SYNC    = 10'd96;
  localparam logic [9:0] H_BP      = 10'd48;
  localparam logic [9:0] H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam logic [9:0] V_VISIBLE = 10'd480;
  localparam logic [9:0] V_FP      = 10'd10;
  localparam logic [9:0] V_SYNC    = 10'd2;
  localparam logic [9:0] V_BP      = 10'd33;
  localparam logic [9:0] V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef logic [11:0] rgb_t;

  localparam rgb_t COL_BLACK = 12'h000;
  localparam rgb_t COL_WHITE = 12'hFFF;
  localparam rgb_t COL_BLUE  = 12'h00F;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_t;

endpackage

// File: rtl/vga_game_timing.sv
// Pixel/line counters with combinational sync, active-area and frame-tick decode.
module vga_timing
  import vga_game_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       i_pix_tick,
  output logic [9:0] o_h_cnt,
  output logic [9:0] o_v_cnt,
  output logic       o_active,
  output logic       o_hsync_n,
  output logic       o_vsync_n,
  output logic       o_frame_tick
);

  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC - 10'd1;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC - 10'd1;

  logic [9:0] r_h_cnt;
  logic [9:0] r_v_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (i_pix_tick) begin
      if (r_h_cnt == H_TOTAL - 10'd1) begin
        r_h_cnt <= '0;
        r_v_cnt <= (r_v_cnt == V_TOTAL - 10'd1) ? '0 : r_v_cnt + 10'd1;
      end else begin
        r_h_cnt <= r_h_cnt + 10'd1;
      end
    end
  end

  assign o_h_cnt      = r_h_cnt;
  assign o_v_cnt      = r_v_cnt;
  assign o_active     = (r_h_cnt < H_VISIBLE) && (r_v_cnt < V_VISIBLE);
  assign o_hsync_n    = !((r_h_cnt >= H_SYNC_START) && (r_h_cnt <= H_SYNC_END));
  assign o_vsync_n    = !((r_v_cnt >= V_SYNC_START) && (r_v_cnt <= V_SYNC_END));
  // First blanking line start: the one point per frame where the ball may move.
  assign o_frame_tick = i_pix_tick && (r_h_cnt == 10'd0) && (r_v_cnt == V_VISIBLE);

endmodule

// File: rtl/vga_game_top.sv
// Autonomous bouncing-ball VGA demo, 640x480@60 from a 100 MHz clock.
// Define GAME_BORDER_EN to draw a blue border and bounce off its inner edge.
module vga_game_top
  import vga_game_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int BALL_SIZE  = 16,
  parameter int BALL_SPEED = 2,
  parameter int BORDER_W   = 8
) (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] pix_r,
  output logic [3:0] pix_g,
  output logic [3:0] pix_b,
  output logic       hsync,
  output logic       vsync
);

`ifdef GAME_BORDER_EN
  localparam bit BORDER_EN = 1'b1;
`else
  localparam bit BORDER_EN = 1'b0;
`endif

  localparam int DIV_W  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int MARGIN = BORDER_EN ? BORDER_W : 0;
  localparam int X_MAX  = int'(H_VISIBLE) - BALL_SIZE - MARGIN;
  localparam int Y_MAX  = int'(V_VISIBLE) - BALL_SIZE - MARGIN;

  localparam logic [9:0] X_RST = 10'((int'(H_VISIBLE) - BALL_SIZE) / 2);
  localparam logic [8:0] Y_RST = 9'((int'(V_VISIBLE) - BALL_SIZE) / 2);

  localparam logic signed [11:0] SPEED_S  = 12'(BALL_SPEED);
  localparam logic signed [11:0] X_MAX_S  = 12'(X_MAX);
  localparam logic signed [11:0] Y_MAX_S  = 12'(Y_MAX);
  localparam logic signed [11:0] MARGIN_S = 12'(MARGIN);

  localparam logic [9:0] BW      = 10'(BORDER_W);
  localparam logic [9:0] H_BD_HI = H_VISIBLE - BW;
  localparam logic [9:0] V_BD_HI = V_VISIBLE - BW;

  logic [DIV_W-1:0]   r_div;
  logic               w_pix_tick;
  logic [9:0]         w_h_cnt;
  logic [9:0]         w_v_cnt;
  logic               w_active;
  logic               w_hsync_n;
  logic               w_vsync_n;
  logic               w_frame_tick;
  logic [9:0]         r_ball_x;
  logic [8:0]         r_ball_y;
  dir_t               r_dir_x;
  dir_t               r_dir_y;
  logic signed [11:0] w_next_x;
  logic signed [11:0] w_next_y;
  logic [10:0]        w_x_end;
  logic [9:0]         w_y_end;
  logic               w_in_ball;
  logic               w_border;
  rgb_t               w_col;

  assign w_pix_tick = (r_div == DIV_W'(CLK_DIV - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst)             r_div <= '0;
    else if (w_pix_tick) r_div <= '0;
    else                 r_div <= r_div + 1'b1;
  end

  vga_timing u_timing (
    .clk          (clk),
    .rst          (rst),
    .i_pix_tick   (w_pix_tick),
    .o_h_cnt      (w_h_cnt),
    .o_v_cnt      (w_v_cnt),
    .o_active     (w_active),
    .o_hsync_n    (w_hsync_n),
    .o_vsync_n    (w_vsync_n),
    .o_frame_tick (w_frame_tick)
  );

  // Signed step so a move past the low wall shows up as negative, not a wrap.
  always_comb begin
    w_next_x = (r_dir_x == DIR_NEG) ? $signed({2'b00, r_ball_x}) - SPEED_S
                                    : $signed({2'b00, r_ball_x}) + SPEED_S;
    w_next_y = (r_dir_y == DIR_NEG) ? $signed({3'b000, r_ball_y}) - SPEED_S
                                    : $signed({3'b000, r_ball_y}) + SPEED_S;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ball_x <= X_RST;
      r_ball_y <= Y_RST;
      r_dir_x  <= DIR_POS;
      r_dir_y  <= DIR_POS;
    end else if (w_frame_tick) begin
      if (w_next_x >= X_MAX_S) begin
        r_ball_x <= 10'(X_MAX);
        r_dir_x  <= DIR_NEG;
      end else if (w_next_x <= MARGIN_S) begin
        r_ball_x <= 10'(MARGIN);
        r_dir_x  <= DIR_POS;
      end else begin
        r_ball_x <= w_next_x[9:0];
      end
      if (w_next_y >= Y_MAX_S) begin
        r_ball_y <= 9'(Y_MAX);
        r_dir_y  <= DIR_NEG;
      end else if (w_next_y <= MARGIN_S) begin
        r_ball_y <= 9'(MARGIN);
        r_dir_y  <= DIR_POS;
      end else begin
        r_ball_y <= w_next_y[8:0];
      end
    end
  end

  assign w_x_end   = {1'b0, r_ball_x} + 11'(BALL_SIZE);
  assign w_y_end   = {1'b0, r_ball_y} + 10'(BALL_SIZE);
  assign w_in_ball = (w_h_cnt >= r_ball_x) && ({1'b0, w_h_cnt} < w_x_end) &&
                     (w_v_cnt >= {1'b0, r_ball_y}) && (w_v_cnt < w_y_end);
  assign w_border  = (w_h_cnt < BW) || (w_h_cnt >= H_BD_HI) ||
                     (w_v_cnt < BW) || (w_v_cnt >= V_BD_HI);

  always_comb begin
    w_col = COL_BLACK;
    if (w_active) begin
      if (BORDER_EN && w_border) w_col = COL_BLUE;
      if (w_in_ball)             w_col = COL_WHITE;
    end
  end

  // Sync and colour share one register stage so they stay pixel-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pix_r <= '0;
      pix_g <= '0;
      pix_b <= '0;
      hsync <= 1'b1;
      vsync <= 1'b1;
    end else if (w_pix_tick) begin
      {pix_r, pix_g, pix_b} <= w_col;
      hsync <= w_hsync_n;
      vsync <= w_vsync_n;
    end
  end

endmodule

// File: tb/tb_vga_game_top.sv
// Directed bench for vga_game_top: sync timing, ball drawing, bounces, async reset.
module tb_vga_game_top;

`ifdef GAME_BORDER_EN
  localparam int          M     = 8;
  localparam logic [11:0] PIX00 = 12'h00F;
  localparam int          BLUES = 16;
`else
  localparam int          M     = 0;
  localparam logic [11:0] PIX00 = 12'h000;
  localparam int          BLUES = 0;
`endif
  localparam int XMAX = 624 - M;
  localparam int YMAX = 464 - M;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] pix_r, pix_g, pix_b;
  logic       hsync, vsync;
  logic [11:0] rgb;

  int errors = 0;
  int checks = 0;
  int edges = 0;
  int blank_bad = 0;
  int sc_cnt, sc_first, sc_last, sc_blue;
  logic [9:0] f_h, f_v, f_bx;
  logic [8:0] f_by;

  assign rgb = {pix_r, pix_g, pix_b};

  vga_game_top dut (
    .clk   (clk),
    .rst   (rst),
    .pix_r (pix_r),
    .pix_g (pix_g),
    .pix_b (pix_b),
    .hsync (hsync),
    .vsync (vsync)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    edges++;
    #1;
    if ((hsync == 1'b0 || vsync == 1'b0) && rgb != 12'h000) blank_bad++;
  endtask

  task automatic step_to(input int n);
    while (edges < n) step();
  endtask

  task automatic next_tick();
    do step(); while (edges % 4 != 0);
  endtask

  task automatic jump(input int h, input int v);
    if (edges % 4 != 0) next_tick();
    f_h = 10'(h);
    f_v = 10'(v);
    force dut.u_timing.r_h_cnt = f_h;
    force dut.u_timing.r_v_cnt = f_v;
    step();
    release dut.u_timing.r_h_cnt;
    release dut.u_timing.r_v_cnt;
  endtask

  task automatic set_ball(input int x, input int y);
    f_bx = 10'(x);
    f_by = 9'(y);
    force dut.r_ball_x = f_bx;
    force dut.r_ball_y = f_by;
    step();
    release dut.r_ball_x;
    release dut.r_ball_y;
  endtask

  task automatic frame();
    jump(0, 480);
    next_tick();
  endtask

  task automatic scan_line(input int v);
    sc_cnt = 0; sc_first = -1; sc_last = -1; sc_blue = 0;
    jump(799, v - 1);
    next_tick();
    for (int k = 0; k < 800; k++) begin
      next_tick();
      if (rgb == 12'hFFF) begin
        if (sc_first < 0) sc_first = k;
        sc_last = k;
        sc_cnt++;
      end
      if (rgb == 12'h00F) sc_blue++;
    end
  endtask

  initial begin
    // Reset state while held
    repeat (3) @(posedge clk);
    #1;
    chk("rst_hsync", int'(hsync), 1);
    chk("rst_vsync", int'(vsync), 1);
    chk("rst_rgb", int'(rgb), 0);

    @(negedge clk); rst = 1'b0; edges = 0;
    step_to(2627); chk("hs_before_pulse", int'(hsync), 1);
    step_to(2628); chk("hs_fall_2628", int'(hsync), 0);
    step_to(3011); chk("hs_low_end", int'(hsync), 0);
    step_to(3012); chk("hs_rise_3012", int'(hsync), 1);
    step_to(5827); chk("hs_line2_pre", int'(hsync), 1);
    step_to(5828); chk("hs_period_3200", int'(hsync), 0);
    chk("vs_high_line1", int'(vsync), 1);

    // Initial ball: lines 232..247, columns 312..327
    scan_line(231); chk("l231_cnt", sc_cnt, 0);
    scan_line(232); chk("l232_cnt", sc_cnt, 16);
    chk("l232_first", sc_first, 312);
    chk("l232_last", sc_last, 327);
    chk("l232_blue", sc_blue, BLUES);
    scan_line(247); chk("l247_cnt", sc_cnt, 16);
    scan_line(248); chk("l248_cnt", sc_cnt, 0);

    // First frame update moves to (314,234)
    frame();
    scan_line(233); chk("f1_l233_cnt", sc_cnt, 0);
    scan_line(234); chk("f1_l234_cnt", sc_cnt, 16);
    chk("f1_l234_first", sc_first, 314);

    // Right wall: from XMAX-2 clamp to XMAX, then come back
    set_ball(XMAX - 2, 234);
    frame();
    scan_line(236); chk("rb_cnt", sc_cnt, 16);
    chk("rb_first", sc_first, XMAX);
    chk("rb_last", sc_last, XMAX + 15);
    frame();
    scan_line(238); chk("rb_back_first", sc_first, XMAX - 2);

    // Left wall: moving left from M+2 clamps to M, then returns
    set_ball(M + 2, 238);
    frame();
    scan_line(240); chk("lb_first", sc_first, M);
    chk("lb_cnt", sc_cnt, 16);
    frame();
    scan_line(242); chk("lb_back_first", sc_first, M + 2);

    // Bottom wall: y clamps to YMAX, then reverses
    set_ball(M + 2, YMAX - 2);
    frame();
    scan_line(YMAX); chk("bb_cnt", sc_cnt, 16);
    chk("bb_first", sc_first, M + 4);
    frame();
    scan_line(YMAX - 2); chk("bb_back_cnt", sc_cnt, 16);
    chk("bb_back_first", sc_first, M + 6);
    scan_line(YMAX + 14); chk("bb_below_cnt", sc_cnt, 0);

    // Vertical sync: low for exactly two lines
    jump(799, 489);
    next_tick(); chk("vs_pre", int'(vsync), 1);
    next_tick(); chk("vs_fall", int'(vsync), 0);
    repeat (1599) next_tick();
    chk("vs_low_end", int'(vsync), 0);
    next_tick(); chk("vs_rise", int'(vsync), 1);

    // Async reset while a white pixel is being driven
    jump(M + 6, YMAX - 2);
    next_tick(); chk("pre_rst_white", int'(rgb), 12'hFFF);
    #2 rst = 1'b1;
    #1 chk("arst_rgb", int'(rgb), 0);
    chk("arst_vsync", int'(vsync), 1);
    @(negedge clk); rst = 1'b0; edges = 0;
    step_to(2628); chk("hs_low_again", int'(hsync), 0);
    #2 rst = 1'b1;
    #1 chk("arst_hsync", int'(hsync), 1);
    @(negedge clk); rst = 1'b0; edges = 0;
    step_to(4); chk("pix00", int'(rgb), int'(PIX00));
    scan_line(232); chk("rst_ball_cnt", sc_cnt, 16);
    chk("rst_ball_first", sc_first, 312);

    chk("blanking_rgb_zero", blank_bad, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/vga_game_top.md
Name: vga_game_top

Overview:
- Self-running VGA game top; top of the FPGA design; drives a 640x480@60 Hz VGA port with 4-bit-per-channel RGB.
- Contains:
  - a pixel-rate enable derived from the 100 MHz system clock;
  - horizontal/vertical timing counters;
  - a bouncing 16x16 square "ball" that updates once per frame;
  - a registered pixel colour mux.
- No user inputs; the demo runs autonomously after reset.

Parameters:
- CLK_DIV, 4, system clocks per pixel (100 MHz / 4 = 25 MHz pixel rate)
- BALL_SIZE, 16, ball edge length in pixels
- BALL_SPEED, 2, pixels moved per frame on each axis
- BORDER_W, 8, border width in pixels (used only with the optional feature)

Ports:
- clk  input  1  system clock, 100 MHz
- rst  input  1  asynchronous active-high reset
- pix_r  output  4  red channel
- pix_g  output  4  green channel
- pix_b  output  4  blue channel
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low

Behaviour:
- Reset (async, active-high) sets every flop:
  - div=0, h_cnt=0, v_cnt=0
  - pix_r/g/b=0, hsync=1, vsync=1
  - ball_x=312, ball_y=232, dir_x=+1, dir_y=+1
- Divider: 2-bit div increments every clk, wrapping 3->0. pix_tick=1 when div==CLK_DIV-1, so the first tick is on the 4th rising edge after reset release.
- Counters (update only on pix_tick):
  - h_cnt counts 0..799, then wraps to 0.
  - v_cnt increments when h_cnt wraps, counts 0..524, then wraps to 0.
- Horizontal timing: visible 0..639, front porch 16, sync 96, back porch 48.
- Vertical timing: visible 0..479, front porch 10, sync 2, back porch 33.
- Sync outputs (registered on pix_tick from the current counter values):
  - hsync=0 iff 656<=h_cnt<=751
  - vsync=0 iff 490<=v_cnt<=491
- RGB outputs (registered on the same pix_tick):
  - 0 whenever h_cnt>=640 or v_cnt>=480.
  - Inside the ball (ball_x<=h_cnt<ball_x+BALL_SIZE and ball_y<=v_cnt<ball_y+BALL_SIZE): R=G=B=4'hF.
  - Otherwise background: 4'h0 on all channels.
- Sync and RGB share the same one-pixel latency, so they stay aligned.
- Ball update:
  - Happens on the pix_tick where h_cnt==0 and v_cnt==480, i.e. exactly once per frame during blanking, so the ball never tears.
  - X axis: next_x = ball_x + dir_x*BALL_SPEED.
    - If next_x >= 640-BALL_SIZE-margin: ball_x = 640-BALL_SIZE-margin and dir_x flips to -1.
    - If next_x <= margin (check with signed or pre-subtract compare so there is no unsigned underflow): ball_x = margin and dir_x flips to +1.
  - Y axis: identical rule with 480.
  - margin = 0 without the border; BORDER_W with it.
  - Corner hit: both directions flip in the same update.
- Position widths: ball_x 10 bits, ball_y 9 bits; counters 10 bits each.
- Reset mid-frame: all outputs return to reset values immediately (asynchronous); timing restarts at h_cnt=v_cnt=0.

Optional Feature:
- Macro: GAME_BORDER_EN.
- Defined:
  - Visible pixels with h_cnt<BORDER_W, h_cnt>=640-BORDER_W, v_cnt<BORDER_W or v_cnt>=480-BORDER_W are drawn blue (R=0, G=0, B=4'hF).
  - The ball takes priority over the border.
  - Bounce margin = BORDER_W.
- Undefined: no border; margin = 0; only black background and white ball.

Decomposition:
- Package vga_game_pkg holds:
  - H_VISIBLE=640, H_FP=16, H_SYNC=96, H_BP=48, H_TOTAL=800
  - V_VISIBLE=480, V_FP=10, V_SYNC=2, V_BP=33, V_TOTAL=525
  - colour constants COL_BLACK, COL_WHITE, COL_BLUE (12-bit)
- One natural sub-module: vga_timing. It takes clk, rst and pix_tick, and outputs h_cnt, v_cnt, active, hsync_n, vsync_n and frame_tick.
- Ball logic and the colour mux stay in the top.

Test Plan:
- Reset release, free-running clk: first pix_tick on the 4th edge; hsync period = 3200 clk; hsync low pulse = 384 clk, beginning 656*4 clk after the line start.
- Frame timing: vsync period = 1,680,000 clk (16.8 ms); vsync low width = 2 lines = 6400 clk.
- Blanking check: whenever hsync==0 or vsync==0, pix_r/g/b must all be 0.
- First frame: white pixels exactly on lines 232..247 at h_cnt 312..327; after the first frame update the ball is at (314,234).
- Bounce: run until ball_x reaches 624 (no border); the next frame must show ball_x=622 with dir_x=-1, and the right edge never exceeds column 639.
- Async reset mid-line: assert rst between edges; hsync=vsync=1 and RGB=0 immediately, ball back at (312,232); with GAME_BORDER_EN, pixel (0,0) reads 4'h00F on blue only.
